pipelined_decoder: RTL and testbench
====================================

Name: pipelined_decoder

Overview:
- Sequential successor to the single-cycle combinational decoder of the 16-bit CPU.
- Decodes the 5-bit opcode and drives PC control, dual-port instruction/data memory addresses and write enables, and register-file write enables.
- Adds pipeline flush after redirects, a two-cycle PLD stall, STP halt, CALL/RTN with a return-address stack, and illegal-opcode and stack-error flags.
- Sits between the instruction memory output and the PC counter, register file and data memory.

Parameters:
- WIDTH, 16, data/address/instruction width (>=16; opcode is always instr[WIDTH-1:WIDTH-5]).
- FLUSH_CYC, 1, cycles squashed after any taken redirect (1..3).
- RAS_DEPTH, 4, return-address stack entries (power of 2, >=2).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr  in  WIDTH  current instruction.
- N  in  WIDTH  immediate/jump target.
- pc  in  WIDTH  current PC.
- rddata, rsdata  in  WIDTH  register-file read data.
- jump  in  1  ALU condition-true for JMP.
- instr_addr1, instr_addr2  out  WIDTH  pc, pc+1 (mod 2^WIDTH).
- data_addr1, data_addr2  out  WIDTH  rddata, rsdata.
- new_pc  out  WIDTH  redirect target.
- cnt_en, pc_sload  out  1  PC increment / PC load.
- instr_Wen2, data_Wen1, data_Wen2  out  1  memory write enables.
- rd_wen, rs_wen, mux1_sel  out  1  register write enables; mux1_sel=1 selects memory data onto the rd write path.
- halted, illegal, ras_err  out  1  status flags.

Behaviour:
- Opcode map:
  - NOP 00000; CALL 00001 with instr[0]=0; RTN 00001 with instr[0]=1.
  - CMP 0001x; JMP 0010x; ADD 0100x; SUB 0101x; MAS 0110x; MOV 0111x.
  - PLD 10000; PST 10010; SET 1011x; LSL 11000; LSR 11010; STP 11111.
  - All other opcodes are illegal.
- States: IDLE, RUN, LOAD, FLUSH, HALT. The state, flush counter, stack pointer, stack entries and sticky flags are all registered.
- Outputs are combinational from state and inputs.
- Reset (rst_n low, asynchronous): state=IDLE, flush count 0, stack empty, illegal=0, ras_err=0.
- IDLE: all enables 0, pc_sload=0, new_pc=0, halted=0. Next state is RUN on the first clock.
- Addresses: instr_addr1/2, data_addr1/2 follow their equations in every state. instr_Wen2=0 and rs_wen=0 always.
- RUN, default: cnt_en=1, pc_sload=0.
  - rd_wen=1 for ADD, SUB, MAS, MOV, SET, LSL, LSR; otherwise 0.
- RUN, PST: data_Wen1=instr[3], data_Wen2=instr[2] for one cycle.
- RUN, PLD: cnt_en=0, rd_wen=0, next state LOAD.
  - LOAD: cnt_en=1, rd_wen=1, mux1_sel=1; next state RUN. mux1_sel=0 in all other cases.
- RUN, JMP with jump=1: pc_sload=1, cnt_en=0, new_pc=N; next state FLUSH, counter loaded with FLUSH_CYC.
  - JMP with jump=0: behaves as NOP.
- RUN, CALL: redirect to N, push pc+1.
  - If the stack is full: no push, ras_err set (sticky); the redirect still happens.
- RUN, RTN: redirect to the top of stack, pop.
  - If the stack is empty: no redirect, ras_err set; behaves as NOP.
- FLUSH: instr is treated as NOP (rd_wen=0, all data write enables 0, no redirect), cnt_en=1.
  - Counter decrements each cycle; return to RUN when it reaches 1.
  - The jump input is ignored.
- RUN, STP: cnt_en=0; next state HALT.
  - HALT: cnt_en=0, pc_sload=0, all enables 0, halted=1. Only reset exits HALT.
- Illegal opcode in RUN: behaves as NOP; illegal set (sticky until reset).
- The jump input is ignored for every opcode except JMP.
- pc+1 wraps modulo 2^WIDTH; a CALL at pc=all-ones pushes 0.
- Reset asserted in any state: outputs revert to IDLE values immediately and the stack contents are lost.

Test Plan:
- Reset release with instr=ADD (0x4000) -> one IDLE cycle with cnt_en=0, then rd_wen=1, cnt_en=1; instr_addr2=pc+1.
- PST instr=0x900C, rddata=0x0020 -> data_addr1=0x0020, data_Wen1=1, data_Wen2=1 for exactly one cycle, rd_wen=0.
- PLD instr=0x8000 -> cycle 1: cnt_en=0, rd_wen=0; cycle 2: rd_wen=1, mux1_sel=1, cnt_en=1.
- JMP instr=0x2000, N=0x0040, jump=1, FLUSH_CYC=2 -> pc_sload=1, new_pc=0x0040, then 2 flush cycles where ADD presented gives rd_wen=0. Repeat with jump=0 -> no pc_sload.
- CALL at pc=0x0010 with N=0x0100, then RTN -> new_pc=0x0011 on RTN. A fifth nested CALL (RAS_DEPTH=4) sets ras_err but still redirects; RTN on an empty stack sets ras_err with no redirect.
- STP 0xF800 -> halted=1, cnt_en=0 held for 10 cycles despite ADD on instr; illegal opcode 0xE000 -> illegal=1 sticky; asserting rst_n low mid-LOAD returns all outputs to IDLE values asynchronously.

Source files
------------

// File: rtl/pipelined_decoder.sv
// Multi-cycle instruction decoder for the 16-bit CPU. It handles redirect flushes,
// the two-cycle PLD, the STP halt, and CALL/RTN through a small return-address stack.
module pipelined_decoder #(
    parameter int WIDTH     = 16,
    parameter int FLUSH_CYC = 1,
    parameter int RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] instr,
    input  logic [WIDTH-1:0] N,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] rddata,
    input  logic [WIDTH-1:0] rsdata,
    input  logic             jump,
    output logic [WIDTH-1:0] instr_addr1,
    output logic [WIDTH-1:0] instr_addr2,
    output logic [WIDTH-1:0] data_addr1,
    output logic [WIDTH-1:0] data_addr2,
    output logic [WIDTH-1:0] new_pc,
    output logic             cnt_en,
    output logic             pc_sload,
    output logic             instr_Wen2,
    output logic             data_Wen1,
    output logic             data_Wen2,
    output logic             rd_wen,
    output logic             rs_wen,
    output logic             mux1_sel,
    output logic             halted,
    output logic             illegal,
    output logic             ras_err
);

    localparam int SPW = $clog2(RAS_DEPTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_FLUSH = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;

    localparam logic [SPW:0] SP_ONE  = (SPW+1)'(1);
    localparam logic [SPW:0] SP_FULL = (SPW+1)'(RAS_DEPTH);
    localparam logic [1:0]   FL_INIT = 2'(FLUSH_CYC);

    logic [2:0]       state, state_nx;
    logic [1:0]       fcnt, fcnt_nx;
    logic [SPW:0]     sp;
    logic [WIDTH-1:0] stack [RAS_DEPTH];

    logic [WIDTH-1:0] pc_inc, ras_top;
    logic [SPW:0]     sp_dec;
    logic             ras_full, ras_empty;
    logic             push, pop, set_ill, set_ras;

    // opcode decode
    logic [4:0] op;
    logic is_nop, is_call, is_rtn, is_cmp, is_jmp, is_pld, is_pst, is_stp, is_wr, is_legal;

    assign op      = instr[WIDTH-1 -: 5];
    assign is_nop  = (op == 5'b00000);
    assign is_call = (op == 5'b00001) && !instr[0];
    assign is_rtn  = (op == 5'b00001) &&  instr[0];
    assign is_cmp  = (op[4:1] == 4'b0001);
    assign is_jmp  = (op[4:1] == 4'b0010);
    assign is_pld  = (op == 5'b10000);
    assign is_pst  = (op == 5'b10010);
    assign is_stp  = (op == 5'b11111);
    assign is_wr   = (op[4:1] == 4'b0100) || (op[4:1] == 4'b0101) || (op[4:1] == 4'b0110) ||
                     (op[4:1] == 4'b0111) || (op[4:1] == 4'b1011) ||
                     (op == 5'b11000) || (op == 5'b11010);
    assign is_legal = is_nop || (op == 5'b00001) || is_cmp || is_jmp || is_pld || is_pst ||
                      is_stp || is_wr;

    logic unused_bits;
    assign unused_bits = ^{instr[WIDTH-6:4], instr[1]};

    assign pc_inc      = pc + WIDTH'(1);
    assign instr_addr1 = pc;
    assign instr_addr2 = pc_inc;
    assign data_addr1  = rddata;
    assign data_addr2  = rsdata;
    assign instr_Wen2  = 1'b0;
    assign rs_wen      = 1'b0;

    assign sp_dec    = sp - SP_ONE;
    assign ras_full  = (sp == SP_FULL);
    assign ras_empty = (sp == '0);
    assign ras_top   = stack[sp_dec[SPW-1:0]];

    always_comb begin
        state_nx  = state;
        fcnt_nx   = fcnt;
        cnt_en    = 1'b0;
        pc_sload  = 1'b0;
        new_pc    = '0;
        data_Wen1 = 1'b0;
        data_Wen2 = 1'b0;
        rd_wen    = 1'b0;
        mux1_sel  = 1'b0;
        halted    = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        set_ill   = 1'b0;
        set_ras   = 1'b0;
        case (state)
            S_IDLE: state_nx = S_RUN;
            S_RUN: begin
                cnt_en = 1'b1;
                rd_wen = is_wr;
                if (is_pst) begin
                    data_Wen1 = instr[3];
                    data_Wen2 = instr[2];
                end else if (is_pld) begin
                    cnt_en   = 1'b0;
                    state_nx = S_LOAD;
                end else if ((is_jmp && jump) || is_call || (is_rtn && !ras_empty)) begin
                    // every taken redirect squashes the next FLUSH_CYC fetches
                    cnt_en   = 1'b0;
                    pc_sload = 1'b1;
                    new_pc   = is_rtn ? ras_top : N;
                    state_nx = S_FLUSH;
                    fcnt_nx  = FL_INIT;
                    push     = is_call && !ras_full;
                    pop      = is_rtn;
                    set_ras  = is_call && ras_full;
                end else if (is_rtn) begin
                    set_ras = 1'b1;
                end else if (is_stp) begin
                    cnt_en   = 1'b0;
                    state_nx = S_HALT;
                end else if (!is_legal) begin
                    set_ill = 1'b1;
                end
            end
            S_LOAD: begin
                cnt_en   = 1'b1;
                rd_wen   = 1'b1;
                mux1_sel = 1'b1;
                state_nx = S_RUN;
            end
            S_FLUSH: begin
                cnt_en = 1'b1;
                if (fcnt <= 2'd1) begin
                    state_nx = S_RUN;
                    fcnt_nx  = '0;
                end else begin
                    fcnt_nx = fcnt - 2'd1;
                end
            end
            S_HALT:  halted = 1'b1;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            fcnt    <= '0;
            sp      <= '0;
            illegal <= 1'b0;
            ras_err <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) stack[i] <= '0;
        end else begin
            state <= state_nx;
            fcnt  <= fcnt_nx;
            if (set_ill) illegal <= 1'b1;
            if (set_ras) ras_err <= 1'b1;
            if (push) begin
                stack[sp[SPW-1:0]] <= pc_inc;
                sp <= sp + SP_ONE;
            end else if (pop) begin
                sp <= sp_dec;
            end
        end
    end

endmodule

// File: tb/tb_pipelined_decoder.sv
// Directed bench for pipelined_decoder: a table of single-cycle vectors plus
// hand-written sequences for the stack, halt and asynchronous-reset corners.
module tb_pipelined_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] instr, N, pc, rddata, rsdata;
    logic        jump;
    logic [15:0] instr_addr1, instr_addr2, data_addr1, data_addr2, new_pc;
    logic        cnt_en, pc_sload, instr_Wen2, data_Wen1, data_Wen2;
    logic        rd_wen, rs_wen, mux1_sel, halted, illegal, ras_err;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    pipelined_decoder #(.WIDTH(16), .FLUSH_CYC(2), .RAS_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .N(N), .pc(pc),
        .rddata(rddata), .rsdata(rsdata), .jump(jump),
        .instr_addr1(instr_addr1), .instr_addr2(instr_addr2),
        .data_addr1(data_addr1), .data_addr2(data_addr2), .new_pc(new_pc),
        .cnt_en(cnt_en), .pc_sload(pc_sload), .instr_Wen2(instr_Wen2),
        .data_Wen1(data_Wen1), .data_Wen2(data_Wen2), .rd_wen(rd_wen),
        .rs_wen(rs_wen), .mux1_sel(mux1_sel), .halted(halted),
        .illegal(illegal), .ras_err(ras_err)
    );

    typedef struct {
        logic [15:0] instr, n, pc, rd;
        logic        j;
        logic        ce, ps;
        logic [15:0] np;
        logic        rw, mx, w1, w2, il;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic [15:0] i, logic [15:0] n, logic [15:0] p, logic [15:0] r,
                                logic j, logic ce, logic ps, logic [15:0] np,
                                logic rw, logic mx, logic w1, logic w2, logic il);
        vec_t v;
        v.instr = i; v.n = n; v.pc = p; v.rd = r; v.j = j;
        v.ce = ce; v.ps = ps; v.np = np; v.rw = rw; v.mx = mx;
        v.w1 = w1; v.w2 = w2; v.il = il;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic put(input logic [15:0] i, input logic [15:0] n, input logic [15:0] p,
                       input logic j);
        instr = i; N = n; pc = p; jump = j;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // one RUN-state cycle: check enables, step the clock
    task automatic cyc(input string nm, input logic [15:0] i, input logic [15:0] n,
                       input logic [15:0] p, input logic ce, input logic ps,
                       input logic [15:0] np);
        put(i, n, p, 1'b0);
        @(negedge clk);
        chk({nm, ".cnt_en"}, 16'(cnt_en), 16'(ce));
        chk({nm, ".pc_sload"}, 16'(pc_sload), 16'(ps));
        if (ps) chk({nm, ".new_pc"}, new_pc, np);
        tick();
    endtask

    task automatic reset_pulse;
        rst_n = 1'b0;
        #1;
        chk("rst.cnt_en", 16'(cnt_en), 16'd0);
        chk("rst.halted", 16'(halted), 16'd0);
        chk("rst.illegal", 16'(illegal), 16'd0);
        chk("rst.ras_err", 16'(ras_err), 16'd0);
        chk("rst.mux1_sel", 16'(mux1_sel), 16'd0);
        chk("rst.rd_wen", 16'(rd_wen), 16'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        put(16'h0000, 16'h0000, 16'h0000, 1'b0);
        tick();
    endtask

    initial begin
        rst_n = 1'b0; rddata = 16'h0; rsdata = 16'h0;
        put(16'h4000, 16'h0000, 16'h0000, 1'b0);

        //             instr    N        pc       rd       j   ce ps np       rw mx w1 w2 il
        vq.push_back(mk(16'h4000,16'h0000,16'h0000,16'h0000,0, 0, 0,16'h0000,0, 0, 0, 0, 0)); // IDLE
        vq.push_back(mk(16'h4000,16'h0000,16'h0000,16'h0000,0, 1, 0,16'h0000,1, 0, 0, 0, 0)); // ADD
        vq.push_back(mk(16'h900C,16'h0000,16'h0001,16'h0020,0, 1, 0,16'h0000,0, 0, 1, 1, 0)); // PST
        vq.push_back(mk(16'h4000,16'h0000,16'h0002,16'h0020,0, 1, 0,16'h0000,1, 0, 0, 0, 0));
        vq.push_back(mk(16'h9008,16'h0000,16'h0003,16'h0030,0, 1, 0,16'h0000,0, 0, 1, 0, 0)); // PST W1 only
        vq.push_back(mk(16'h8000,16'h0000,16'h0004,16'h0000,0, 0, 0,16'h0000,0, 0, 0, 0, 0)); // PLD
        vq.push_back(mk(16'h8000,16'h0000,16'h0004,16'h0000,0, 1, 0,16'h0000,1, 1, 0, 0, 0)); // LOAD
        vq.push_back(mk(16'h2000,16'h0040,16'h0005,16'h0000,1, 0, 1,16'h0040,0, 0, 0, 0, 0)); // JMP taken
        vq.push_back(mk(16'h4000,16'h0000,16'h0040,16'h0000,1, 1, 0,16'h0000,0, 0, 0, 0, 0)); // FLUSH 1
        vq.push_back(mk(16'h900C,16'h0000,16'h0041,16'h0000,0, 1, 0,16'h0000,0, 0, 0, 0, 0)); // FLUSH 2
        vq.push_back(mk(16'h4000,16'h0000,16'h0042,16'h0000,0, 1, 0,16'h0000,1, 0, 0, 0, 0));
        vq.push_back(mk(16'h2000,16'h0080,16'h0043,16'h0000,0, 1, 0,16'h0000,0, 0, 0, 0, 0)); // JMP not taken
        vq.push_back(mk(16'h4000,16'h0080,16'h0044,16'h0000,1, 1, 0,16'h0000,1, 0, 0, 0, 0)); // jump ignored
        vq.push_back(mk(16'h1000,16'h0080,16'h0045,16'h0000,1, 1, 0,16'h0000,0, 0, 0, 0, 0)); // CMP
        vq.push_back(mk(16'h0800,16'h0100,16'h0010,16'h0000,0, 0, 1,16'h0100,0, 0, 0, 0, 0)); // CALL
        vq.push_back(mk(16'h0801,16'h0000,16'h0100,16'h0000,0, 1, 0,16'h0000,0, 0, 0, 0, 0)); // RTN squashed
        vq.push_back(mk(16'h0801,16'h0000,16'h0101,16'h0000,0, 1, 0,16'h0000,0, 0, 0, 0, 0));
        vq.push_back(mk(16'h0801,16'h0000,16'h0102,16'h0000,0, 0, 1,16'h0011,0, 0, 0, 0, 0)); // RTN
        vq.push_back(mk(16'h0000,16'h0000,16'h0011,16'h0000,0, 1, 0,16'h0000,0, 0, 0, 0, 0));
        vq.push_back(mk(16'h0000,16'h0000,16'h0012,16'h0000,0, 1, 0,16'h0000,0, 0, 0, 0, 0));
        vq.push_back(mk(16'hE000,16'h0000,16'hFFFF,16'h0000,0, 1, 0,16'h0000,0, 0, 0, 0, 0)); // illegal
        vq.push_back(mk(16'h4000,16'h0000,16'h0000,16'h0000,0, 1, 0,16'h0000,1, 0, 0, 0, 1));
        vq.push_back(mk(16'hB000,16'h0000,16'h0001,16'h0000,0, 1, 0,16'h0000,1, 0, 0, 0, 1)); // SET
        vq.push_back(mk(16'h5000,16'h0000,16'h0002,16'h0000,0, 1, 0,16'h0000,1, 0, 0, 0, 1)); // SUB
        vq.push_back(mk(16'h6000,16'h0000,16'h0003,16'h0000,0, 1, 0,16'h0000,1, 0, 0, 0, 1)); // MAS
        vq.push_back(mk(16'h7000,16'h0000,16'h0004,16'h0000,0, 1, 0,16'h0000,1, 0, 0, 0, 1)); // MOV
        vq.push_back(mk(16'hC000,16'h0000,16'h0005,16'h0000,0, 1, 0,16'h0000,1, 0, 0, 0, 1)); // LSL
        vq.push_back(mk(16'hD000,16'h0000,16'h0006,16'h0000,0, 1, 0,16'h0000,1, 0, 0, 0, 1)); // LSR
        vq.push_back(mk(16'h8800,16'h0000,16'h0007,16'h0000,0, 1, 0,16'h0000,0, 0, 0, 0, 1)); // illegal
        vq.push_back(mk(16'h0000,16'h0000,16'h0008,16'h0000,0, 1, 0,16'h0000,0, 0, 0, 0, 1)); // NOP

        // held in reset: IDLE outputs
        @(negedge clk);
        chk("inrst.cnt_en", 16'(cnt_en), 16'd0);
        chk("inrst.rd_wen", 16'(rd_wen), 16'd0);
        chk("inrst.new_pc", new_pc, 16'h0000);
        tick();
        rst_n = 1'b1;

        for (int k = 0; k < vq.size(); k++) begin
            string nm;
            nm = $sformatf("v%0d", k);
            put(vq[k].instr, vq[k].n, vq[k].pc, vq[k].j);
            rddata = vq[k].rd;
            rsdata = ~vq[k].rd;
            @(negedge clk);
            chk({nm, ".cnt_en"},    16'(cnt_en),    16'(vq[k].ce));
            chk({nm, ".pc_sload"},  16'(pc_sload),  16'(vq[k].ps));
            if (vq[k].ps || k == 0) chk({nm, ".new_pc"}, new_pc, vq[k].np);
            chk({nm, ".rd_wen"},    16'(rd_wen),    16'(vq[k].rw));
            chk({nm, ".mux1_sel"},  16'(mux1_sel),  16'(vq[k].mx));
            chk({nm, ".data_Wen1"}, 16'(data_Wen1), 16'(vq[k].w1));
            chk({nm, ".data_Wen2"}, 16'(data_Wen2), 16'(vq[k].w2));
            chk({nm, ".illegal"},   16'(illegal),   16'(vq[k].il));
            chk({nm, ".ras_err"},   16'(ras_err),   16'd0);
            chk({nm, ".halted"},    16'(halted),    16'd0);
            chk({nm, ".rs_wen"},    16'({rs_wen, instr_Wen2}), 16'd0);
            chk({nm, ".instr_addr1"}, instr_addr1, vq[k].pc);
            chk({nm, ".instr_addr2"}, instr_addr2, vq[k].pc + 16'd1);
            chk({nm, ".data_addr1"},  data_addr1,  vq[k].rd);
            chk({nm, ".data_addr2"},  data_addr2,  ~vq[k].rd);
            tick();
        end
        rddata = 16'h0; rsdata = 16'h0;

        // STP then ten cycles of ADD: stays halted
        cyc("stp", 16'hF800, 16'h0000, 16'h0009, 1'b0, 1'b0, 16'h0);
        for (int k = 0; k < 10; k++) begin
            put(16'h4000, 16'h0000, 16'h000A, 1'b1);
            @(negedge clk);
            chk($sformatf("halt%0d.halted", k), 16'(halted), 16'd1);
            chk($sformatf("halt%0d.cnt_en", k), 16'(cnt_en), 16'd0);
            chk($sformatf("halt%0d.rd_wen", k), 16'(rd_wen | pc_sload), 16'd0);
            tick();
        end
        reset_pulse();

        // RTN on an empty stack: no redirect, ras_err next cycle
        cyc("rtn_empty", 16'h0801, 16'h0000, 16'h0050, 1'b1, 1'b0, 16'h0);
        @(negedge clk);
        chk("rtn_empty.ras_err", 16'(ras_err), 16'd1);
        reset_pulse();

        // five nested CALLs with a depth-4 stack; the fourth is at pc=FFFF
        begin
            logic [15:0] cpc[5];
            logic [15:0] cn[5];
            logic [15:0] rexp[4];
            cpc = '{16'h0010, 16'h0100, 16'h0200, 16'hFFFF, 16'h0400};
            cn  = '{16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500};
            rexp = '{16'h0000, 16'h0201, 16'h0101, 16'h0011};
            for (int k = 0; k < 5; k++) begin
                cyc($sformatf("call%0d", k), 16'h0800, cn[k], cpc[k], 1'b0, 1'b1, cn[k]);
                @(negedge clk);
                chk($sformatf("call%0d.ras_err", k), 16'(ras_err), (k == 4) ? 16'd1 : 16'd0);
                cyc($sformatf("callfl%0d", k), 16'h0000, 16'h0000, cn[k], 1'b1, 1'b0, 16'h0);
                cyc($sformatf("callfl%0d", k), 16'h0000, 16'h0000, cn[k] + 16'd1, 1'b1, 1'b0, 16'h0);
            end
            for (int k = 0; k < 4; k++) begin
                cyc($sformatf("rtn%0d", k), 16'h0801, 16'h0000, 16'h0600, 1'b0, 1'b1, rexp[k]);
                cyc($sformatf("rtnfl%0d", k), 16'h0000, 16'h0000, rexp[k], 1'b1, 1'b0, 16'h0);
                cyc($sformatf("rtnfl%0d", k), 16'h0000, 16'h0000, rexp[k] + 16'd1, 1'b1, 1'b0, 16'h0);
            end
            cyc("rtn_under", 16'h0801, 16'h0000, 16'h0700, 1'b1, 1'b0, 16'h0);
        end

        // asynchronous reset in the middle of LOAD
        cyc("pld", 16'h8000, 16'h0000, 16'h0800, 1'b0, 1'b0, 16'h0);
        put(16'h8000, 16'h0000, 16'h0800, 1'b0);
        @(negedge clk);
        chk("load.mux1_sel", 16'(mux1_sel), 16'd1);
        chk("load.rd_wen", 16'(rd_wen), 16'd1);
        #2;
        reset_pulse();
        cyc("post_rst", 16'h4000, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
